netlist_pipe_datapath: RTL and testbench

Parametrised, pipelined successor to the team's single-stage add/compare/select/shift netlist datapath. It computes two sums and a difference, compares the sums, selects results and applies variable shifts. It adds WIDTH generalisation, a signed/unsigned mode, runtime shift amounts, overflow flags and a 3-stage valid/ready pipeline with per-stage bubble collapse. It sits between an operand producer and a result consumer, both using valid/ready.

---
 rtl/netlist_pkg.sv | 17 +
 rtl/netlist_pipe_datapath_pipe_stage.sv | 32 +++
 rtl/netlist_pipe_datapath.sv | 156 +++++++++++++++
 tb/tb_netlist_pipe_datapath.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/netlist_pkg.sv
// Shared constants and types for the pipelined add/compare/select/shift datapath.
package netlist_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Mode encodings for the sgn input
    localparam logic SGN_SIGNED   = 1'b1;
    localparam logic SGN_UNSIGNED = 1'b0;

    // Overflow flags as they appear on the ovf port: {f, e, d}
    typedef struct packed {
        logic f;
        logic e;
        logic d;
    } ovf_t;

endpackage

// File: rtl/netlist_pipe_datapath_pipe_stage.sv
// One valid/ready pipeline slot: a valid bit plus a payload register.
// The ready signal is combinational backward so empty slots collapse bubbles.
module pipe_stage #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          ready_c,
    output logic          valid,
    input  logic          dn_ready,
    input  logic [PW-1:0] data_d,
    output logic [PW-1:0] data_q
);

    // Slot can load when empty or when its contents leave this cycle
    assign ready_c = ~valid | dn_ready;

    // Valid and payload move forward on load; payload only captured for real beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            data_q <= '0;
        end else if (ready_c) begin
            valid <= up_valid;
            if (up_valid) begin
                data_q <= data_d;
            end
        end
    end

endmodule

// File: rtl/netlist_pipe_datapath.sv
// Three-stage valid/ready datapath: sums/difference with overflow, exact
// compare, select, then variable left/right shifts into the output registers.
module netlist_pipe_datapath
    import netlist_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             sgn,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] z,
    output logic             lt,
    output logic             eq,
    output logic [2:0]       ovf
);

    localparam int unsigned XW  = WIDTH + 1;
    localparam int unsigned OW  = 3;
    localparam int unsigned PW1 = 2 * XW + WIDTH + OW + 1 + SHW;
    localparam int unsigned PW2 = 2 * WIDTH + 2 + 1 + SHW + OW;
    localparam int unsigned PW3 = 2 * WIDTH + 2 + OW;

    // ready chain, valid chain
    logic s1_ready, s2_ready, s3_ready;
    logic s1_valid, s2_valid;

    // ---------------- stage 1 arithmetic ----------------
    logic [XW-1:0]  a_x, b_x, c_x;
    logic [XW-1:0]  d1_x, e1_x, f1_x;
    ovf_t           ovf1;
    logic [PW1-1:0] s1_d, s1_q;

    // Extend operands one bit so sums are exact, and derive overflow from the top bits
    always_comb begin
        a_x  = {sgn & a[WIDTH-1], a};
        b_x  = {sgn & b[WIDTH-1], b};
        c_x  = {sgn & c[WIDTH-1], c};
        d1_x = a_x + b_x;
        e1_x = a_x + c_x;
        f1_x = a_x - b_x;
        ovf1 = '0;
        if (sgn == SGN_SIGNED) begin
            ovf1.d = d1_x[WIDTH] ^ d1_x[WIDTH-1];
            ovf1.e = e1_x[WIDTH] ^ e1_x[WIDTH-1];
            ovf1.f = f1_x[WIDTH] ^ f1_x[WIDTH-1];
        end else begin
            ovf1.d = d1_x[WIDTH];
            ovf1.e = e1_x[WIDTH];
            ovf1.f = f1_x[WIDTH];
        end
    end

    assign s1_d = {d1_x, e1_x, f1_x[WIDTH-1:0], ovf1, sgn, shamt};

    pipe_stage #(.PW(PW1)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .ready_c  (s1_ready),
        .valid    (s1_valid),
        .dn_ready (s2_ready),
        .data_d   (s1_d),
        .data_q   (s1_q)
    );

    assign in_ready = s1_ready;

    logic [XW-1:0]    s1_dx, s1_ex;
    logic [WIDTH-1:0] s1_f;
    ovf_t             s1_ovf;
    logic             s1_sgn;
    logic [SHW-1:0]   s1_shamt;

    assign {s1_dx, s1_ex, s1_f, s1_ovf, s1_sgn, s1_shamt} = s1_q;

    // ---------------- stage 2 compare / select ----------------
    logic             lt2, eq2;
    logic [WIDTH-1:0] g2, h2;
    logic [PW2-1:0]   s2_d, s2_q;

    // Compare on the exact extended sums, then pick g and h
    always_comb begin
        if (s1_sgn == SGN_UNSIGNED) begin
            lt2 = s1_dx < s1_ex;
        end else begin
            lt2 = $signed(s1_dx) < $signed(s1_ex);
        end
        eq2 = s1_dx == s1_ex;
        g2  = lt2 ? s1_ex[WIDTH-1:0] : s1_dx[WIDTH-1:0];
        h2  = eq2 ? s1_f : g2;
    end

    assign s2_d = {g2, h2, lt2, eq2, s1_sgn, s1_shamt, s1_ovf};

    pipe_stage #(.PW(PW2)) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s1_valid),
        .ready_c  (s2_ready),
        .valid    (s2_valid),
        .dn_ready (s3_ready),
        .data_d   (s2_d),
        .data_q   (s2_q)
    );

    logic [WIDTH-1:0] s2_g, s2_h;
    logic             s2_lt, s2_eq, s2_sgn;
    logic [SHW-1:0]   s2_shamt;
    ovf_t             s2_ovf;

    assign {s2_g, s2_h, s2_lt, s2_eq, s2_sgn, s2_shamt, s2_ovf} = s2_q;

    // ---------------- stage 3 shifts ----------------
    logic [WIDTH-1:0] x3, z3;
    logic [PW3-1:0]   s3_d, s3_q;

    // Left shift on lt, right shift on eq (arithmetic when signed)
    always_comb begin
        x3 = s2_g << (s2_lt ? s2_shamt : SHW'(0));
        z3 = s2_h;
        if (s2_eq) begin
            if (s2_sgn == SGN_SIGNED) begin
                z3 = WIDTH'($signed(s2_h) >>> s2_shamt);
            end else begin
                z3 = s2_h >> s2_shamt;
            end
        end
    end

    assign s3_d = {x3, z3, s2_lt, s2_eq, s2_ovf};

    pipe_stage #(.PW(PW3)) u_s3 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s2_valid),
        .ready_c  (s3_ready),
        .valid    (out_valid),
        .dn_ready (out_ready),
        .data_d   (s3_d),
        .data_q   (s3_q)
    );

    // Output registers are the stage-3 payload
    assign {x, z, lt, eq, ovf} = s3_q;

endmodule

// File: tb/tb_netlist_pipe_datapath.sv
// Self-checking bench: directed vector table, randomized stream against a
// scoreboard model, stall/backpressure and mid-flight reset sequences.
module tb_netlist_pipe_datapath;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b, c;
    logic          sgn;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  x, z;
    logic          lt, eq;
    logic [2:0]    ovf;

    netlist_pipe_datapath #(.WIDTH(W), .SHW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .sgn       (sgn),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .z         (z),
        .lt        (lt),
        .eq        (eq),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] z;
        logic         lt;
        logic         eq;
        logic [2:0]   ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  c;
        logic          sgn;
        logic [SW-1:0] sh;
        logic [W-1:0]  x;
        logic [W-1:0]  z;
        logic          lt;
        logic          eq;
        logic [2:0]    ovf;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_in  = 0;
    int   n_out = 0;
    exp_t exp_q[$];
    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: exact integer arithmetic, overflow = result outside the representable range
    function automatic exp_t model(input logic [W-1:0] av_i, input logic [W-1:0] bv_i,
                                   input logic [W-1:0] cv_i, input logic s,
                                   input logic [SW-1:0] sh);
        longint av, bv, cv, dx, ex, fx, lo, hi, hs;
        logic [63:0] dbits, ebits, fbits;
        logic [W-1:0] d, e, f, g, h;
        exp_t r;
        av = s ? longint'($signed(av_i)) : longint'(av_i);
        bv = s ? longint'($signed(bv_i)) : longint'(bv_i);
        cv = s ? longint'($signed(cv_i)) : longint'(cv_i);
        lo = s ? -64'sd2147483648 : 64'sd0;
        hi = s ? 64'sd2147483647 : 64'sd4294967295;
        dx = av + bv;
        ex = av + cv;
        fx = av - bv;
        dbits = dx;
        ebits = ex;
        fbits = fx;
        d = dbits[W-1:0];
        e = ebits[W-1:0];
        f = fbits[W-1:0];
        r.ovf[0] = (dx < lo) || (dx > hi);
        r.ovf[1] = (ex < lo) || (ex > hi);
        r.ovf[2] = (fx < lo) || (fx > hi);
        r.lt = dx < ex;
        r.eq = dx == ex;
        g = r.lt ? e : d;
        h = r.eq ? f : g;
        r.x = W'(longint'(g) << (r.lt ? int'(sh) : 0));
        hs = s ? longint'($signed(h)) : longint'(h);
        r.z = W'(hs >>> (r.eq ? int'(sh) : 0));
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand(input logic v);
        a        = rnd_op();
        b        = rnd_op();
        c        = ($urandom_range(0, 3) == 0) ? b : rnd_op();
        sgn      = 1'($urandom_range(0, 1));
        shamt    = SW'($urandom_range(0, 31));
        in_valid = v;
    endtask

    // Scoreboard: push accepted beats, check every presented output against the oldest
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                n_in -= exp_q.size();
                exp_q.delete();
            end else begin
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(a, b, c, sgn, shamt));
                    n_in++;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", out_valid, 1'b0);
                    end else begin
                        e = exp_q[0];
                        chk("sb_x", x, e.x);
                        chk("sb_z", z, e.z);
                        chk("sb_lt", lt, e.lt);
                        chk("sb_eq", eq, e.eq);
                        chk("sb_ovf", ovf, e.ovf);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            n_out++;
                        end
                    end
                end
            end
        end
    end

    task automatic send_and_check(input vec_t v, input int idx);
        @(negedge clk);
        a = v.a; b = v.b; c = v.c; sgn = v.sgn; shamt = v.sh;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk($sformatf("vec%0d_in_ready", idx), in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk($sformatf("vec%0d_early_valid", idx), out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_out_valid", idx), out_valid, 1'b1);
        chk($sformatf("vec%0d_x", idx), x, v.x);
        chk($sformatf("vec%0d_z", idx), z, v.z);
        chk($sformatf("vec%0d_lt", idx), lt, v.lt);
        chk($sformatf("vec%0d_eq", idx), eq, v.eq);
        chk($sformatf("vec%0d_ovf", idx), ovf, v.ovf);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #3;
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(name, done, 1'b1);
    endtask

    initial begin
        int acc;
        vt[0]  = '{32'd5,        32'd3,        32'd1,  1'b1, 5'd2,  32'd8,        32'd8,        1'b0, 1'b0, 3'b000};
        vt[1]  = '{32'd1,        32'd2,        32'd4,  1'b1, 5'd3,  32'd40,       32'd5,        1'b1, 1'b0, 3'b000};
        vt[2]  = '{32'hFFFFFFF6, 32'd3,        32'd3,  1'b1, 5'd1,  32'hFFFFFFF9, 32'hFFFFFFF9, 1'b0, 1'b1, 3'b000};
        vt[3]  = '{32'hFFFFFFF6, 32'd3,        32'd3,  1'b0, 5'd1,  32'hFFFFFFF9, 32'h7FFFFFF9, 1'b0, 1'b1, 3'b000};
        vt[4]  = '{32'h7FFFFFFF, 32'd1,        32'd0,  1'b1, 5'd4,  32'h80000000, 32'h80000000, 1'b0, 1'b0, 3'b001};
        vt[5]  = '{32'hFFFFFFFF, 32'd1,        32'd2,  1'b0, 5'd5,  32'd32,       32'd1,        1'b1, 1'b0, 3'b011};
        vt[6]  = '{32'd2,        32'd5,        32'd2,  1'b0, 5'd1,  32'd7,        32'd7,        1'b0, 1'b0, 3'b100};
        vt[7]  = '{32'h80000000, 32'hFFFFFFFF, 32'd1,  1'b1, 5'd3,  32'd8,        32'h80000001, 1'b1, 1'b0, 3'b001};
        vt[8]  = '{32'h80000000, 32'd0,        32'd0,  1'b1, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 3'b000};
        vt[9]  = '{32'h80000000, 32'd0,        32'd0,  1'b0, 5'd31, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 3'b000};
        vt[10] = '{32'd1,        32'd0,        32'd1,  1'b0, 5'd31, 32'd0,        32'd2,        1'b1, 1'b0, 3'b000};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; sgn = 1'b0; shamt = '0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_x", x, 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_flags", {lt, eq, ovf}, 5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1'b1);

        // directed vectors
        for (int i = 0; i < 11; i++) send_and_check(vt[i], i);
        drain("drain_vectors");

        // random stream with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_rand($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        drain("drain_random");

        // stall: back-to-back beats while the consumer refuses for 5 cycles
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive_rand(1'b1);
            #1 if (in_ready) acc++;
        end
        chk("stall_accepted", acc, 3);
        chk("stall_in_ready_full", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        // release with input still offered: accept and emit in the same cycle
        @(negedge clk);
        out_ready = 1'b1;
        drive_rand(1'b1);
        #1 chk("full_accept_emit", in_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_rand(1'b1);
        end
        drain("drain_stall");

        // reset with beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'd5; b = 32'd3; c = 32'd1; sgn = 1'b1; shamt = 5'd2; in_valid = 1'b1;
        @(negedge clk);
        a = 32'd1; b = 32'd2; c = 32'd4; shamt = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("inflight_out_valid", out_valid, 1'b1);
        chk("inflight_x", x, 32'd8);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_x", x, 32'd0);
        chk("midrst_z", z, 32'd0);
        chk("midrst_flags", {lt, eq, ovf}, 5'd0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("post_rst_no_beat", out_valid, 1'b0);
        end
        send_and_check(vt[1], 100);
        drain("drain_final");
        chk("beats_in_eq_out", n_out, n_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
